// File: rtl/mcu_arbiter.sv
// Two-requester round-robin front end for a single-command mcu: IDLE -> ISSUE -> CAPTURE -> RESP.
// Optional macro MCU_ARB_OPCHK_EN rejects opcodes above 8 at grant without touching the mcu.
module mcu_arbiter #(
  parameter int OP_SZ  = 32,
  parameter int MEM_SZ = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rq0_valid,
  output logic              rq0_ready,
  input  logic [3:0]        rq0_op,
  input  logic [MEM_SZ-1:0] rq0_op0,
  input  logic [OP_SZ-1:0]  rq0_op1,
  input  logic [MEM_SZ-1:0] rq0_op2,
  input  logic              rq1_valid,
  output logic              rq1_ready,
  input  logic [3:0]        rq1_op,
  input  logic [MEM_SZ-1:0] rq1_op0,
  input  logic [OP_SZ-1:0]  rq1_op1,
  input  logic [MEM_SZ-1:0] rq1_op2,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [OP_SZ-1:0]  rsp_data,
  output logic              rsp_err,
  output logic [3:0]        mcu_op,
  output logic [MEM_SZ-1:0] mcu_op0,
  output logic [OP_SZ-1:0]  mcu_op1,
  output logic [MEM_SZ-1:0] mcu_op2,
  input  logic [OP_SZ-1:0]  mcu_out,
  input  logic              mcu_op_err,
  output logic [1:0]        dbg_state
);

  localparam logic [3:0] OP_READ = 4'd7;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  // Handshake: a command transfers on a rising edge where rqN_valid && rqN_ready;
  // ready is only ever offered in IDLE and to at most one requester.
  state_t              state;
  logic                last_gnt;
  logic                gnt_id;
  logic                grant0;
  logic                grant1;
  logic                bad_op;
  logic [3:0]          sel_op;
  logic [MEM_SZ-1:0]   sel_op0;
  logic [OP_SZ-1:0]    sel_op1;
  logic [MEM_SZ-1:0]   sel_op2;

  // last_gnt resets to 1 so rq0 wins the first tie.
  always_comb begin
    grant0  = reset && (state == IDLE) && rq0_valid && (!rq1_valid || last_gnt);
    grant1  = reset && (state == IDLE) && rq1_valid && (!rq0_valid || !last_gnt);
    sel_op  = grant1 ? rq1_op  : rq0_op;
    sel_op0 = grant1 ? rq1_op0 : rq0_op0;
    sel_op1 = grant1 ? rq1_op1 : rq0_op1;
    sel_op2 = grant1 ? rq1_op2 : rq0_op2;
  end

`ifdef MCU_ARB_OPCHK_EN
  assign bad_op = (sel_op > 4'd8);
`else
  assign bad_op = 1'b0;
`endif

  assign rq0_ready = grant0;
  assign rq1_ready = grant1;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_gnt   <= 1'b1;
      gnt_id     <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      mcu_op     <= OP_READ;
      mcu_op0    <= '0;
      mcu_op1    <= '0;
      mcu_op2    <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            gnt_id   <= grant1;
            last_gnt <= grant1;
            if (bad_op) begin
              state      <= RESP;
              rsp_data   <= '0;
              rsp_err    <= 1'b1;
              rsp0_valid <= grant0;
              rsp1_valid <= grant1;
            end else begin
              // The mcu command registers double as the captured command.
              state   <= ISSUE;
              mcu_op  <= sel_op;
              mcu_op0 <= sel_op0;
              mcu_op1 <= sel_op1;
              mcu_op2 <= sel_op2;
            end
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          state      <= RESP;
          rsp_data   <= mcu_out;
          rsp_err    <= mcu_op_err;
          rsp0_valid <= !gnt_id;
          rsp1_valid <= gnt_id;
          mcu_op     <= OP_READ;
          mcu_op0    <= '0;
          mcu_op1    <= '0;
          mcu_op2    <= '0;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_arbiter.sv
// Directed bench for mcu_arbiter with a small behavioural mcu (memory plus ALU) behind it.
module tb_mcu_arbiter;

  logic        clk;
  logic        reset;
  logic        rq0_valid, rq1_valid;
  logic        rq0_ready, rq1_ready;
  logic [3:0]  rq0_op, rq1_op;
  logic [9:0]  rq0_op0, rq1_op0, rq0_op2, rq1_op2;
  logic [31:0] rq0_op1, rq1_op1;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  mcu_op;
  logic [9:0]  mcu_op0, mcu_op2;
  logic [31:0] mcu_op1;
  logic [31:0] mcu_out;
  logic        mcu_op_err;
  logic [1:0]  dbg_state;

  int n_chk;
  int n_fail;

  mcu_arbiter #(.OP_SZ(32), .MEM_SZ(10)) dut (
    .clk(clk), .reset(reset),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_op(rq0_op),
    .rq0_op0(rq0_op0), .rq0_op1(rq0_op1), .rq0_op2(rq0_op2),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_op(rq1_op),
    .rq1_op0(rq1_op0), .rq1_op1(rq1_op1), .rq1_op2(rq1_op2),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mcu_op(mcu_op), .mcu_op0(mcu_op0), .mcu_op1(mcu_op1), .mcu_op2(mcu_op2),
    .mcu_out(mcu_out), .mcu_op_err(mcu_op_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural mcu: op0/op1 are source addresses, op2 the destination
  logic [31:0] mem [0:1023];
  logic [31:0] ma, mb;
  always_comb begin
    ma = mem[mcu_op0];
    mb = mem[mcu_op1[9:0]];
    mcu_out = '0;
    mcu_op_err = 1'b0;
    case (mcu_op)
      4'd0: mcu_out = ma + mb;
      4'd1: mcu_out = ma - mb;
      4'd2: mcu_out = ma * mb;
      4'd3: if (mb == 0) mcu_op_err = 1'b1; else mcu_out = ma / mb;
      4'd4: mcu_out = ma & mb;
      4'd5: mcu_out = ma | mb;
      4'd6: mcu_out = ma ^ mb;
      4'd7: mcu_out = ma;
      4'd8: mcu_out = mcu_op1;
      default: mcu_op_err = 1'b1;
    endcase
  end
  always @(posedge clk) begin
    if (mcu_op <= 4'd6) mem[mcu_op2] <= mcu_out;
    else if (mcu_op == 4'd8) mem[mcu_op0] <= mcu_op1;
  end

  // driver tasks
  task automatic set_rq(input int n, input logic v, input logic [3:0] op, input logic [9:0] a,
                        input logic [31:0] b, input logic [9:0] c);
    if (n == 0) begin
      rq0_valid = v; rq0_op = op; rq0_op0 = a; rq0_op1 = b; rq0_op2 = c;
    end else begin
      rq1_valid = v; rq1_op = op; rq1_op0 = a; rq1_op1 = b; rq1_op2 = c;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    set_rq(0, 1'b0, 4'd0, 10'd0, 32'd0, 10'd0);
    set_rq(1, 1'b0, 4'd0, 10'd0, 32'd0, 10'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Issues one command, then scrambles the fields (valid kept while hold=1 until RESP).
  task automatic do_cmd(input int n, input logic [3:0] op, input logic [9:0] a, input logic [31:0] b,
                        input logic [9:0] c, input bit hold, output bit acc, output int lat,
                        output logic [31:0] data, output logic err, output bit wrong,
                        output logic [23:0] m1, output logic [23:0] m2);
    acc = 1'b0; lat = 0; data = '0; err = 1'b0; wrong = 1'b0; m1 = '0; m2 = '0;
    @(negedge clk);
    set_rq(n, 1'b1, op, a, b, c);
    for (int i = 0; i < 12; i++) begin
      #1;
      if (((n == 0) ? rq0_ready : rq1_ready) === 1'b1) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) begin
      set_rq(n, 1'b0, 4'd0, 10'd0, 32'd0, 10'd0);
      return;
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) set_rq(n, hold, 4'd8, 10'd5, 32'd999, 10'd6);
      if (i == 3) set_rq(n, 1'b0, 4'd8, 10'd5, 32'd999, 10'd6);
      #1;
      if (i == 1) m1 = {mcu_op, mcu_op0, mcu_op2};
      if (i == 2) m2 = {mcu_op, mcu_op0, mcu_op2};
      if (((n == 0) ? rsp1_valid : rsp0_valid) === 1'b1) wrong = 1'b1;
      if (((n == 0) ? rsp0_valid : rsp1_valid) === 1'b1) begin
        lat = i; data = rsp_data; err = rsp_err;
        break;
      end
    end
    set_rq(n, 1'b0, 4'd0, 10'd0, 32'd0, 10'd0);
  endtask

  bit          acc, wrong;
  int          lat;
  logic [31:0] data;
  logic        err;
  logic [23:0] m1, m2;

  task automatic test_reset();
    set_rq(0, 1'b1, 4'd8, 10'd200, 32'd5, 10'd0);
    set_rq(1, 1'b1, 4'd8, 10'd201, 32'd6, 10'd0);
    #1;
    n_chk++; if (rq0_ready !== 1'b0 || rq1_ready !== 1'b0) begin n_fail++;
      $display("FAIL rst_ready: got %b%b want 00", rq0_ready, rq1_ready); end
    n_chk++; if ({rsp0_valid, rsp1_valid, rsp_err} !== 3'b000 || rsp_data !== 32'd0) begin n_fail++;
      $display("FAIL rst_rsp: got v=%b%b err=%b data=%0d want 0", rsp0_valid, rsp1_valid, rsp_err, rsp_data); end
    n_chk++; if ({mcu_op, mcu_op0, mcu_op2} !== {4'd7, 10'd0, 10'd0} || mcu_op1 !== 32'd0) begin n_fail++;
      $display("FAIL rst_mcu: got op=%0d op0=%0d op1=%0d op2=%0d want 7 0 0 0", mcu_op, mcu_op0, mcu_op1, mcu_op2); end
    n_chk++; if (dbg_state !== 2'd0) begin n_fail++;
      $display("FAIL rst_state: got %0d want 0", dbg_state); end
    repeat (2) @(negedge clk);
    set_rq(1, 1'b0, 4'd0, 10'd0, 32'd0, 10'd0);
    reset = 1'b1;
    #1;
    n_chk++; if (rq0_ready !== 1'b1 || rq1_ready !== 1'b0) begin n_fail++;
      $display("FAIL first_grant: got %b%b want 10", rq0_ready, rq1_ready); end
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) set_rq(0, 1'b0, 4'd0, 10'd0, 32'd0, 10'd0);
      #1;
      if (rsp0_valid === 1'b1 && lat == 0) lat = i;
    end
    n_chk++; if (lat != 3) begin n_fail++;
      $display("FAIL first_lat: got %0d want 3", lat); end
  endtask

  task automatic test_write_add();
    do_cmd(0, 4'd8, 10'd100, 32'd2, 10'd0, 1'b0, acc, lat, data, err, wrong, m1, m2);
    n_chk++; if (!acc || lat != 3) begin n_fail++;
      $display("FAIL wr100_lat: got acc=%0d lat=%0d want 1 3", acc, lat); end
    n_chk++; if (m1 !== {4'd8, 10'd100, 10'd0} || m2 !== {4'd8, 10'd100, 10'd0}) begin n_fail++;
      $display("FAIL wr100_mcu: got %h %h want %h", m1, m2, {4'd8, 10'd100, 10'd0}); end
    do_cmd(0, 4'd8, 10'd101, 32'd1, 10'd0, 1'b0, acc, lat, data, err, wrong, m1, m2);
    n_chk++; if (!acc || lat != 3) begin n_fail++;
      $display("FAIL wr101_lat: got acc=%0d lat=%0d want 1 3", acc, lat); end
    do_cmd(0, 4'd0, 10'd100, 32'd101, 10'd102, 1'b0, acc, lat, data, err, wrong, m1, m2);
    n_chk++; if (!acc || lat != 3 || wrong) begin n_fail++;
      $display("FAIL add_lat: got acc=%0d lat=%0d wrong=%0d want 1 3 0", acc, lat, wrong); end
    n_chk++; if (data !== 32'd3 || err !== 1'b0) begin n_fail++;
      $display("FAIL add_data: got %0d err=%b want 3 err=0", data, err); end
    n_chk++; if (m1 !== {4'd0, 10'd100, 10'd102}) begin n_fail++;
      $display("FAIL add_mcu: got %h want %h", m1, {4'd0, 10'd100, 10'd102}); end
  endtask

  task automatic test_both_valid();
    int l0, l1, g1;
    logic [31:0] d0, d1;
    l0 = 0; l1 = 0; g1 = 0; d0 = '0; d1 = '0;
    apply_reset();
    @(negedge clk);
    set_rq(0, 1'b1, 4'd1, 10'd100, 32'd101, 10'd102);
    set_rq(1, 1'b1, 4'd1, 10'd100, 32'd101, 10'd102);
    #1;
    n_chk++; if (rq0_ready !== 1'b1 || rq1_ready !== 1'b0) begin n_fail++;
      $display("FAIL tie_grant: got %b%b want 10", rq0_ready, rq1_ready); end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) set_rq(0, 1'b0, 4'd0, 10'd0, 32'd0, 10'd0);
      if (i == g1 + 1 && g1 != 0) set_rq(1, 1'b0, 4'd0, 10'd0, 32'd0, 10'd0);
      #1;
      if (rsp0_valid === 1'b1 && l0 == 0) begin l0 = i; d0 = rsp_data; end
      if (rsp1_valid === 1'b1 && l1 == 0) begin l1 = i; d1 = rsp_data; end
      if (rq1_ready === 1'b1 && g1 == 0) g1 = i;
    end
    set_rq(1, 1'b0, 4'd0, 10'd0, 32'd0, 10'd0);
    n_chk++; if (l0 != 3 || d0 !== 32'd1) begin n_fail++;
      $display("FAIL tie_rsp0: got lat=%0d data=%0d want 3 1", l0, d0); end
    n_chk++; if (g1 != 4) begin n_fail++;
      $display("FAIL tie_grant1: got cycle %0d want 4", g1); end
    n_chk++; if (l1 != 7 || d1 !== 32'd1) begin n_fail++;
      $display("FAIL tie_rsp1: got lat=%0d data=%0d want 7 1", l1, d1); end
  endtask

  task automatic test_round_robin();
    int ngnt, nrsp, expg, pend, last_cyc;
    ngnt = 0; nrsp = 0; expg = 0; pend = 0; last_cyc = 0;
    set_rq(0, 1'b0, 4'd7, 10'd100, 32'd0, 10'd0);
    set_rq(1, 1'b0, 4'd7, 10'd101, 32'd0, 10'd0);
    for (int cyc = 0; cyc < 60 && nrsp < 8; cyc++) begin
      @(negedge clk);
      rq0_valid = (ngnt < 8);
      rq1_valid = (ngnt < 8);
      #1;
      if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
        n_chk++; if (rsp0_valid !== (pend == 0) || rsp1_valid !== (pend == 1)) begin n_fail++;
          $display("FAIL rr_rsp: got %b%b want to rq%0d", rsp0_valid, rsp1_valid, pend); end
        nrsp++;
      end
      if (rq0_ready === 1'b1 || rq1_ready === 1'b1) begin
        n_chk++; if (rq0_ready !== (expg == 0) || rq1_ready !== (expg == 1)) begin n_fail++;
          $display("FAIL rr_grant: got %b%b want rq%0d", rq0_ready, rq1_ready, expg); end
        if (ngnt > 0) begin
          n_chk++; if (cyc - last_cyc != 4) begin n_fail++;
            $display("FAIL rr_gap: got %0d want 4", cyc - last_cyc); end
        end
        last_cyc = cyc; pend = expg; expg = 1 - expg; ngnt++;
      end
    end
    set_rq(0, 1'b0, 4'd0, 10'd0, 32'd0, 10'd0);
    set_rq(1, 1'b0, 4'd0, 10'd0, 32'd0, 10'd0);
    n_chk++; if (ngnt != 8 || nrsp != 8) begin n_fail++;
      $display("FAIL rr_count: got %0d grants %0d rsps want 8 8", ngnt, nrsp); end
  endtask

  task automatic test_bad_op();
    do_cmd(1, 4'd10, 10'd3, 32'd4, 10'd5, 1'b0, acc, lat, data, err, wrong, m1, m2);
`ifdef MCU_ARB_OPCHK_EN
    n_chk++; if (!acc || lat != 1 || wrong) begin n_fail++;
      $display("FAIL badop_lat: got acc=%0d lat=%0d wrong=%0d want 1 1 0", acc, lat, wrong); end
    n_chk++; if (m1 !== {4'd7, 10'd0, 10'd0}) begin n_fail++;
      $display("FAIL badop_mcu: got %h want %h", m1, {4'd7, 10'd0, 10'd0}); end
`else
    n_chk++; if (!acc || lat != 3 || wrong) begin n_fail++;
      $display("FAIL badop_lat: got acc=%0d lat=%0d wrong=%0d want 1 3 0", acc, lat, wrong); end
    n_chk++; if (m1 !== {4'd10, 10'd3, 10'd5}) begin n_fail++;
      $display("FAIL badop_mcu: got %h want %h", m1, {4'd10, 10'd3, 10'd5}); end
`endif
    n_chk++; if (err !== 1'b1 || data !== 32'd0) begin n_fail++;
      $display("FAIL badop_rsp: got err=%b data=%0d want 1 0", err, data); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    do_cmd(1, 4'd8, 10'd1000, 32'd50, 10'd0, 1'b0, acc, lat, data, err, wrong, m1, m2);
    do_cmd(1, 4'd8, 10'd1001, 32'd7, 10'd0, 1'b0, acc, lat, data, err, wrong, m1, m2);
    @(negedge clk);
    set_rq(0, 1'b1, 4'd3, 10'd1000, 32'd1001, 10'd1002);
    #1;
    n_chk++; if (rq0_ready !== 1'b1) begin n_fail++;
      $display("FAIL div_accept: got %b want 1", rq0_ready); end
    @(negedge clk);
    set_rq(0, 1'b0, 4'd0, 10'd0, 32'd0, 10'd0);
    @(negedge clk);
    #1;
    n_chk++; if (dbg_state !== 2'd2) begin n_fail++;
      $display("FAIL div_capture: got state %0d want 2", dbg_state); end
    reset = 1'b0;
    #1;
    n_chk++; if ({rsp0_valid, rsp1_valid, rsp_err} !== 3'b000 || rsp_data !== 32'd0 || dbg_state !== 2'd0) begin n_fail++;
      $display("FAIL mid_rst_rsp: got v=%b%b err=%b data=%0d st=%0d want 0", rsp0_valid, rsp1_valid, rsp_err, rsp_data, dbg_state); end
    n_chk++; if ({mcu_op, mcu_op0, mcu_op2} !== {4'd7, 10'd0, 10'd0} || mcu_op1 !== 32'd0) begin n_fail++;
      $display("FAIL mid_rst_mcu: got op=%0d op0=%0d op1=%0d op2=%0d want 7 0 0 0", mcu_op, mcu_op0, mcu_op1, mcu_op2); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_chk++; if (seen) begin n_fail++;
      $display("FAIL mid_rst_pulse: got response after reset want none"); end
    do_cmd(0, 4'd7, 10'd1000, 32'd0, 10'd0, 1'b0, acc, lat, data, err, wrong, m1, m2);
    n_chk++; if (!acc || lat != 3 || data !== 32'd50 || err !== 1'b0) begin n_fail++;
      $display("FAIL read1000: got acc=%0d lat=%0d data=%0d err=%b want 1 3 50 0", acc, lat, data, err); end
  endtask

  task automatic test_withdraw();
    bit g1, r1;
    int r0;
    g1 = 1'b0; r1 = 1'b0; r0 = 0;
    @(negedge clk);
    set_rq(0, 1'b1, 4'd7, 10'd100, 32'd0, 10'd0);
    #1;
    n_chk++; if (rq0_ready !== 1'b1) begin n_fail++;
      $display("FAIL wd_accept: got %b want 1", rq0_ready); end
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) begin
        set_rq(0, 1'b0, 4'd0, 10'd0, 32'd0, 10'd0);
        set_rq(1, 1'b1, 4'd7, 10'd101, 32'd0, 10'd0);
      end
      if (i == 2) set_rq(1, 1'b0, 4'd0, 10'd0, 32'd0, 10'd0);
      #1;
      if (rq1_ready === 1'b1) g1 = 1'b1;
      if (rsp1_valid === 1'b1) r1 = 1'b1;
      if (rsp0_valid === 1'b1) r0++;
    end
    n_chk++; if (g1 || r1 || r0 != 1) begin n_fail++;
      $display("FAIL withdraw: got grant1=%0d rsp1=%0d rsp0=%0d want 0 0 1", g1, r1, r0); end
  endtask

  task automatic test_hold();
    do_cmd(0, 4'd0, 10'd100, 32'd101, 10'd103, 1'b1, acc, lat, data, err, wrong, m1, m2);
    n_chk++; if (!acc || lat != 3 || data !== 32'd3 || err !== 1'b0) begin n_fail++;
      $display("FAIL hold_rsp: got acc=%0d lat=%0d data=%0d err=%b want 1 3 3 0", acc, lat, data, err); end
    n_chk++; if (m2 !== {4'd0, 10'd100, 10'd103}) begin n_fail++;
      $display("FAIL hold_mcu: got %h want %h", m2, {4'd0, 10'd100, 10'd103}); end
    n_chk++; if (mem[5] === 32'd999) begin n_fail++;
      $display("FAIL hold_leak: got mem[5]=%0d want untouched", mem[5]); end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    set_rq(0, 1'b0, 4'd0, 10'd0, 32'd0, 10'd0);
    set_rq(1, 1'b0, 4'd0, 10'd0, 32'd0, 10'd0);
    #1 reset = 1'b0;
    test_reset();
    test_write_add();
    test_both_valid();
    test_round_robin();
    test_bad_op();
    test_reset_mid();
    test_withdraw();
    test_hold();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
